deque_stream_adapter: RTL and testbench
=======================================

# deque_stream_adapter

Request-side controller for the double-ended queue. It converts two independent valid/ready request streams, one per deque end, into the queue's single-cycle push/pop strobes, and returns pop data on per-end valid/ready response streams. It keeps its own occupancy count and never issues an overflow, an underflow, an illegal same-end push+pop, or a push into a full queue. It sits between the producer/consumer logic and one deque instance.

## Interface
- WORD_WIDTH, 32, data word width (must match the deque)
- MAX_SIZE, 40, deque capacity (must match the deque)
- ADDR_WIDTH, clog2(MAX_SIZE), address width; count is ADDR_WIDTH+1 bits
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- front_req_valid / back_req_valid  in  1  request present at that end
- front_req_op / back_req_op  in  1  1 = push, 0 = pop
- front_req_data / back_req_data  in  WORD_WIDTH  push data, ignored for pops
- front_req_ready / back_req_ready  out  1  request accepted when valid && ready
- front_rsp_valid / back_rsp_valid  out  1  pop data available
- front_rsp_ready / back_rsp_ready  in  1  consumer takes pop data
- front_rsp_data / back_rsp_data  out  WORD_WIDTH  captured pop data
- dq_front_push, dq_front_pop, dq_back_push, dq_back_pop  out  1  strobes to the deque
- dq_front_push_data / dq_back_push_data  out  WORD_WIDTH  push data to the deque
- dq_front_pop_data / dq_back_pop_data  in  WORD_WIDTH  registered pop data from the deque
- count  out  ADDR_WIDTH+1  adapter-tracked occupancy, 0..MAX_SIZE

## Operation
- Per-end response FSM: IDLE -> CAP -> RSP -> IDLE.
  - IDLE -> CAP on an accepted pop.
  - CAP: capture dq_*_pop_data into rsp_data, then go to RSP.
  - RSP: rsp_valid=1; on rsp_ready go to IDLE.
- Pops are accepted only in IDLE. Pushes are accepted in any FSM state.
- Push eligibility: valid && op=1 && count + (pushes granted this cycle) < MAX_SIZE.
- Pop eligibility: valid && op=0 && FSM=IDLE && count > (pops granted this cycle).
- Same-cycle ops at the opposite end give no credit. A push at count==MAX_SIZE is refused even when the other end pops. A pop at count==0 is refused even when the other end pushes.
- Conflicts:
  - Both ends push at count==MAX_SIZE-1, or both pop at count==1: only one is granted.
  - The winner is chosen by the `pri` bit (0 = back wins). `pri` toggles only after a conflict.
  - Non-conflicting requests at both ends are granted together.
- The dq strobe equals the corresponding valid && ready && op term. Push data passes through combinationally.
- count next = count + granted pushes − granted pops. Width is ADDR_WIDTH+1 and the value never leaves 0..MAX_SIZE.
- req_ready may depend combinationally on both ends' req_valid/op. Requesters must not make valid depend on ready.
- Reset values: count=0, both FSMs IDLE, rsp_valid=0, rsp_data=0, pri=0. While rst_n=0, all req_ready and dq strobes are 0.
- Reset asserted mid-operation discards outstanding responses. The integrator must reset the deque in the same window.

## Timing
- Push accepted in cycle N: dq push strobe in N, count updated in N+1.
- Pop accepted in cycle N:
  - dq pop strobe in N; the deque registers data at the end of N.
  - CAP in N+1; rsp_valid=1 from N+2.
- rsp_ready in the first RSP cycle returns the FSM to IDLE in N+3. Maximum pop rate is one per 3 cycles per end.
- rsp_valid and rsp_data are held stable until the handshake completes.

## Test plan
- Reset, then back push 0xA1, 0xA2, 0xA3 on consecutive cycles, then front pop -> count 3, then 2; front_rsp_data=0xA1 two cycles after acceptance.
- Fill to 40 via back pushes, then push on the front -> front_req_ready=0 and count stays 40; then front pop with simultaneous back push -> only the pop is granted and count=39.
- Count=39, both ends push in the same cycle, twice -> first conflict grants back (pri=0) and count=40; after draining to 39, the second conflict grants front.
- Count=0, front pop with simultaneous back push 0x55 -> pop refused and push granted; retried pop returns 0x55.
- Hold back_rsp_ready=0 for 5 cycles after a pop -> back_rsp_valid held high with stable data; a back pop in that window is refused; back pushes are still accepted.
- Assert rst_n low mid-response with count=7 -> rsp_valid, count, and all strobes drop to 0 asynchronously.

Source files
------------

// File: rtl/deque_stream_adapter.sv
// deque_stream_adapter
// Request-side controller for a double-ended queue. Two valid/ready request
// streams (front end, back end) are turned into single-cycle push/pop strobes
// for the deque. Pop data returns on per-end valid/ready response streams.
// The adapter tracks occupancy itself and only grants operations that keep
// the deque within 0..MAX_SIZE, so the deque never sees an overflow, an
// underflow or a push+pop at the same end in one cycle.
module deque_stream_adapter #(
    parameter int WORD_WIDTH = 32,
    parameter int MAX_SIZE   = 40,
    parameter int ADDR_WIDTH = $clog2(MAX_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  front_req_valid,
    input  logic                  front_req_op,
    input  logic [WORD_WIDTH-1:0] front_req_data,
    output logic                  front_req_ready,

    input  logic                  back_req_valid,
    input  logic                  back_req_op,
    input  logic [WORD_WIDTH-1:0] back_req_data,
    output logic                  back_req_ready,

    output logic                  front_rsp_valid,
    input  logic                  front_rsp_ready,
    output logic [WORD_WIDTH-1:0] front_rsp_data,

    output logic                  back_rsp_valid,
    input  logic                  back_rsp_ready,
    output logic [WORD_WIDTH-1:0] back_rsp_data,

    output logic                  dq_front_push,
    output logic                  dq_front_pop,
    output logic                  dq_back_push,
    output logic                  dq_back_pop,
    output logic [WORD_WIDTH-1:0] dq_front_push_data,
    output logic [WORD_WIDTH-1:0] dq_back_push_data,
    input  logic [WORD_WIDTH-1:0] dq_front_pop_data,
    input  logic [WORD_WIDTH-1:0] dq_back_pop_data,

    output logic [ADDR_WIDTH:0]   count
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] FULL_CNT    = CW'(MAX_SIZE);
    localparam logic [CW-1:0] NEAR_FULL   = CW'(MAX_SIZE - 1);
    localparam logic [CW-1:0] ONE_CNT     = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAP  = 2'd1,
        RSP  = 2'd2
    } rsp_state_t;

    rsp_state_t    front_state;
    rsp_state_t    back_state;
    logic [CW-1:0] count_q;
    logic          pri;           // conflict winner: 0 = back, 1 = front

    logic front_push_req;
    logic back_push_req;
    logic front_pop_req;
    logic back_pop_req;
    logic has_room;
    logic has_data;
    logic push_conflict;
    logic pop_conflict;
    logic front_push_gnt;
    logic back_push_gnt;
    logic front_pop_gnt;
    logic back_pop_gnt;

    // Occupancy after this cycle's granted operations. Grants are computed so
    // that the result always stays inside 0..MAX_SIZE.
    function automatic logic [CW-1:0] next_count(
        input logic [CW-1:0] cnt,
        input logic          push_a,
        input logic          push_b,
        input logic          pop_a,
        input logic          pop_b
    );
        next_count = cnt + CW'(push_a) + CW'(push_b) - CW'(pop_a) - CW'(pop_b);
    endfunction

    // Request decode. Pops only while that end's response path is idle;
    // pushes regardless of the response state.
    always_comb begin
        front_push_req = front_req_valid && front_req_op;
        back_push_req  = back_req_valid  && back_req_op;
        front_pop_req  = front_req_valid && !front_req_op && (front_state == IDLE);
        back_pop_req   = back_req_valid  && !back_req_op  && (back_state  == IDLE);

        // Eligibility looks only at the registered count: an operation at the
        // opposite end in the same cycle never frees a slot or supplies data.
        has_room = (count_q < FULL_CNT);
        has_data = (count_q != '0);

        // Only one slot left, or only one word left, and both ends want it.
        push_conflict = front_push_req && back_push_req && (count_q == NEAR_FULL);
        pop_conflict  = front_pop_req  && back_pop_req  && (count_q == ONE_CNT);

        front_push_gnt = front_push_req && has_room && !(push_conflict && !pri);
        back_push_gnt  = back_push_req  && has_room && !(push_conflict &&  pri);
        front_pop_gnt  = front_pop_req  && has_data && !(pop_conflict  && !pri);
        back_pop_gnt   = back_pop_req   && has_data && !(pop_conflict  &&  pri);
    end

    // Ready and strobes are forced low while reset is held, since the
    // deque is being reset in the same window.
    always_comb begin
        front_req_ready    = rst_n && (front_push_gnt || front_pop_gnt);
        back_req_ready     = rst_n && (back_push_gnt  || back_pop_gnt);
        dq_front_push      = front_req_valid && front_req_ready &&  front_req_op;
        dq_front_pop       = front_req_valid && front_req_ready && !front_req_op;
        dq_back_push       = back_req_valid  && back_req_ready  &&  back_req_op;
        dq_back_pop        = back_req_valid  && back_req_ready  && !back_req_op;
        dq_front_push_data = front_req_data;
        dq_back_push_data  = back_req_data;
    end

    assign count = count_q;

    // Occupancy tracking and the round-robin conflict priority bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            pri     <= 1'b0;
        end else begin
            count_q <= next_count(count_q, dq_front_push, dq_back_push,
                                  dq_front_pop, dq_back_pop);
            if (push_conflict || pop_conflict) begin
                pri <= ~pri;
            end
        end
    end

    // Front response path: wait one cycle for the deque's registered pop
    // data, capture it, then hold it until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_state     <= IDLE;
            front_rsp_valid <= 1'b0;
            front_rsp_data  <= '0;
        end else begin
            case (front_state)
                IDLE: begin
                    if (dq_front_pop) begin
                        front_state <= CAP;
                    end
                end
                CAP: begin
                    front_rsp_data  <= dq_front_pop_data;
                    front_rsp_valid <= 1'b1;
                    front_state     <= RSP;
                end
                RSP: begin
                    if (front_rsp_ready) begin
                        front_rsp_valid <= 1'b0;
                        front_state     <= IDLE;
                    end
                end
                default: begin
                    front_rsp_valid <= 1'b0;
                    front_state     <= IDLE;
                end
            endcase
        end
    end

    // Back response path, identical to the front one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            back_state     <= IDLE;
            back_rsp_valid <= 1'b0;
            back_rsp_data  <= '0;
        end else begin
            case (back_state)
                IDLE: begin
                    if (dq_back_pop) begin
                        back_state <= CAP;
                    end
                end
                CAP: begin
                    back_rsp_data  <= dq_back_pop_data;
                    back_rsp_valid <= 1'b1;
                    back_state     <= RSP;
                end
                RSP: begin
                    if (back_rsp_ready) begin
                        back_rsp_valid <= 1'b0;
                        back_state     <= IDLE;
                    end
                end
                default: begin
                    back_rsp_valid <= 1'b0;
                    back_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deque_stream_adapter.sv
// Testbench for deque_stream_adapter: a behavioural deque answers the strobes,
// a reference content queue predicts pop data, and each scenario task checks
// grants, count and responses inline.
module tb_deque_stream_adapter;

    localparam int W   = 32;
    localparam int MAX = 40;
    localparam int AW  = $clog2(MAX);
    localparam int CW  = AW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          front_req_valid, front_req_op, front_req_ready;
    logic [W-1:0]  front_req_data;
    logic          back_req_valid, back_req_op, back_req_ready;
    logic [W-1:0]  back_req_data;
    logic          front_rsp_valid, front_rsp_ready;
    logic [W-1:0]  front_rsp_data;
    logic          back_rsp_valid, back_rsp_ready;
    logic [W-1:0]  back_rsp_data;
    logic          dq_front_push, dq_front_pop, dq_back_push, dq_back_pop;
    logic [W-1:0]  dq_front_push_data, dq_back_push_data;
    logic [W-1:0]  dq_front_pop_data, dq_back_pop_data;
    logic [CW-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] dq_mem[$];     // contents of the emulated deque
    logic [W-1:0] ref_q[$];      // predicted contents
    logic [W-1:0] exp_front[$];  // scoreboard of expected front responses
    logic [W-1:0] exp_back[$];   // scoreboard of expected back responses

    deque_stream_adapter #(.WORD_WIDTH(W), .MAX_SIZE(MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .front_req_valid(front_req_valid), .front_req_op(front_req_op),
        .front_req_data(front_req_data), .front_req_ready(front_req_ready),
        .back_req_valid(back_req_valid), .back_req_op(back_req_op),
        .back_req_data(back_req_data), .back_req_ready(back_req_ready),
        .front_rsp_valid(front_rsp_valid), .front_rsp_ready(front_rsp_ready),
        .front_rsp_data(front_rsp_data),
        .back_rsp_valid(back_rsp_valid), .back_rsp_ready(back_rsp_ready),
        .back_rsp_data(back_rsp_data),
        .dq_front_push(dq_front_push), .dq_front_pop(dq_front_pop),
        .dq_back_push(dq_back_push), .dq_back_pop(dq_back_pop),
        .dq_front_push_data(dq_front_push_data), .dq_back_push_data(dq_back_push_data),
        .dq_front_pop_data(dq_front_pop_data), .dq_back_pop_data(dq_back_pop_data),
        .count(count)
    );

    always #5 clk = ~clk;

    // Behavioural deque with registered pop data.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_mem.delete();
            dq_front_pop_data <= '0;
            dq_back_pop_data  <= '0;
        end else begin
            if (dq_front_pop && dq_mem.size() > 0) dq_front_pop_data <= dq_mem.pop_front();
            if (dq_back_pop  && dq_mem.size() > 0) dq_back_pop_data  <= dq_mem.pop_back();
            if (dq_front_push) dq_mem.push_front(dq_front_push_data);
            if (dq_back_push)  dq_mem.push_back(dq_back_push_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        front_req_valid = 1'b0; front_req_op = 1'b0; front_req_data = '0;
        back_req_valid  = 1'b0; back_req_op  = 1'b0; back_req_data  = '0;
    endtask

    task automatic drive(input bit fr, input bit op, input logic [W-1:0] d);
        if (fr) begin
            front_req_valid = 1'b1; front_req_op = op; front_req_data = d;
        end else begin
            back_req_valid = 1'b1; back_req_op = op; back_req_data = d;
        end
    endtask

    // One request at one end for one cycle; reports whether it was accepted.
    task automatic issue(input bit fr, input bit op, input logic [W-1:0] d, output bit ok);
        drive(fr, op, d);
        #1;
        ok = fr ? front_req_ready : back_req_ready;
        step();
        clear_req();
    endtask

    // Bounded wait for a response; steps once past it so a ready consumer takes it.
    task automatic wait_rsp(input bit fr, output logic [W-1:0] d, output bit to);
        bit seen;
        seen = 1'b0;
        d = '0;
        for (int i = 0; i < 16 && !seen; i++) begin
            if (fr ? front_rsp_valid : back_rsp_valid) begin
                seen = 1'b1;
                d = fr ? front_rsp_data : back_rsp_data;
            end
            step();
        end
        to = !seen;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        clear_req();
        front_rsp_ready = 1'b1;
        back_rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        ref_q.delete();
        exp_front.delete();
        exp_back.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_req();
        front_rsp_ready = 1'b1;
        back_rsp_ready  = 1'b1;
        drive(1, 1, 32'h11);
        drive(0, 1, 32'h22);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (count !== '0 || front_rsp_valid !== 1'b0 || back_rsp_valid !== 1'b0 ||
            front_rsp_data !== '0 || back_rsp_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d fv=%b bv=%b fd=%h bd=%h, want all 0",
                     count, front_rsp_valid, back_rsp_valid, front_rsp_data, back_rsp_data);
        end
        n_tests++;
        if (front_req_ready !== 1'b0 || back_req_ready !== 1'b0 ||
            dq_front_push !== 1'b0 || dq_back_push !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: frdy=%b brdy=%b fpush=%b bpush=%b, want 0",
                     front_req_ready, back_req_ready, dq_front_push, dq_back_push);
        end
        clear_req();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_push_pop();
        logic [W-1:0] v;
        logic [W-1:0] e;
        bit bad;
        reset_dut();
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v = 32'hA1 + W'(i);
            drive(0, 1, v);
            #1;
            if (back_req_ready !== 1'b1 || dq_back_push !== 1'b1 || dq_back_push_data !== v) bad = 1'b1;
            ref_q.push_back(v);
            step();
            clear_req();
        end
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL push_strobes: back push of A1..A3 not passed through, want ready=1 strobe=1"); end
        n_tests++;
        if (count !== CW'(3)) begin n_fail++; $display("FAIL push_count: got %0d want 3", count); end
        drive(1, 0, '0);
        #1;
        n_tests++;
        if (front_req_ready !== 1'b1 || dq_front_pop !== 1'b1) begin
            n_fail++;
            $display("FAIL pop_accept: ready=%b strobe=%b want 1 1", front_req_ready, dq_front_pop);
        end
        exp_front.push_back(ref_q.pop_front());
        step();
        clear_req();
        n_tests++;
        if (count !== CW'(2) || front_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_cap_cycle: count=%0d rsp_valid=%b want 2 0", count, front_rsp_valid);
        end
        step();
        e = exp_front.pop_front();
        n_tests++;
        if (front_rsp_valid !== 1'b1 || front_rsp_data !== e) begin
            n_fail++;
            $display("FAIL pop_rsp: valid=%b data=%h want 1 %h", front_rsp_valid, front_rsp_data, e);
        end
        step();
        n_tests++;
        if (front_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_release: valid=%b want 0", front_rsp_valid); end
    endtask

    task automatic test_full();
        bit ok, bad, to;
        logic [W-1:0] d, e;
        reset_dut();
        bad = 1'b0;
        for (int i = 0; i < MAX; i++) begin
            issue(0, 1, 32'h100 + W'(i), ok);
            if (!ok) bad = 1'b1;
            ref_q.push_back(32'h100 + W'(i));
        end
        n_tests++;
        if (bad || count !== CW'(MAX)) begin
            n_fail++;
            $display("FAIL fill: refused=%b count=%0d want 0 %0d", bad, count, MAX);
        end
        drive(1, 1, 32'hDEAD);
        #1;
        n_tests++;
        if (front_req_ready !== 1'b0 || dq_front_push !== 1'b0) begin
            n_fail++;
            $display("FAIL full_push: ready=%b strobe=%b want 0 0", front_req_ready, dq_front_push);
        end
        step();
        clear_req();
        n_tests++;
        if (count !== CW'(MAX)) begin n_fail++; $display("FAIL full_count: got %0d want %0d", count, MAX); end
        drive(1, 0, '0);
        drive(0, 1, 32'h200);
        #1;
        n_tests++;
        if (front_req_ready !== 1'b1 || back_req_ready !== 1'b0 || dq_back_push !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop_push: frdy=%b brdy=%b bpush=%b want 1 0 0",
                     front_req_ready, back_req_ready, dq_back_push);
        end
        exp_front.push_back(ref_q.pop_front());
        step();
        clear_req();
        n_tests++;
        if (count !== CW'(MAX - 1)) begin n_fail++; $display("FAIL full_pop_count: got %0d want %0d", count, MAX - 1); end
        wait_rsp(1, d, to);
        e = exp_front.pop_front();
        n_tests++;
        if (to || d !== e) begin n_fail++; $display("FAIL full_pop_data: timeout=%b data=%h want %h", to, d, e); end
    endtask

    // Continues from test_full with count = MAX-1.
    task automatic test_conflict();
        bit ok, to;
        logic [W-1:0] d, e;
        drive(1, 1, 32'hF0);
        drive(0, 1, 32'hB0);
        #1;
        n_tests++;
        if (back_req_ready !== 1'b1 || front_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict1: frdy=%b brdy=%b want 0 1", front_req_ready, back_req_ready);
        end
        ref_q.push_back(32'hB0);
        step();
        clear_req();
        n_tests++;
        if (count !== CW'(MAX)) begin n_fail++; $display("FAIL conflict1_count: got %0d want %0d", count, MAX); end
        issue(0, 0, '0, ok);
        exp_back.push_back(ref_q.pop_back());
        wait_rsp(0, d, to);
        e = exp_back.pop_front();
        n_tests++;
        if (!ok || to || d !== e || count !== CW'(MAX - 1)) begin
            n_fail++;
            $display("FAIL drain_back: ok=%b timeout=%b data=%h count=%0d want 1 0 %h %0d",
                     ok, to, d, count, e, MAX - 1);
        end
        drive(1, 1, 32'hF1);
        drive(0, 1, 32'hB1);
        #1;
        n_tests++;
        if (front_req_ready !== 1'b1 || back_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict2: frdy=%b brdy=%b want 1 0", front_req_ready, back_req_ready);
        end
        ref_q.push_front(32'hF1);
        step();
        clear_req();
        issue(1, 0, '0, ok);
        exp_front.push_back(ref_q.pop_front());
        wait_rsp(1, d, to);
        e = exp_front.pop_front();
        n_tests++;
        if (!ok || to || d !== e) begin
            n_fail++;
            $display("FAIL conflict2_data: ok=%b timeout=%b data=%h want 1 0 %h", ok, to, d, e);
        end
    endtask

    task automatic test_empty();
        bit ok, to;
        logic [W-1:0] d, e;
        reset_dut();
        drive(1, 0, '0);
        drive(0, 1, 32'h55);
        #1;
        n_tests++;
        if (front_req_ready !== 1'b0 || dq_front_pop !== 1'b0 || back_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_pop_push: frdy=%b fpop=%b brdy=%b want 0 0 1",
                     front_req_ready, dq_front_pop, back_req_ready);
        end
        ref_q.push_back(32'h55);
        step();
        clear_req();
        n_tests++;
        if (count !== CW'(1)) begin n_fail++; $display("FAIL empty_count: got %0d want 1", count); end
        issue(1, 0, '0, ok);
        exp_front.push_back(ref_q.pop_front());
        wait_rsp(1, d, to);
        e = exp_front.pop_front();
        n_tests++;
        if (!ok || to || d !== e || count !== '0) begin
            n_fail++;
            $display("FAIL empty_retry: ok=%b timeout=%b data=%h count=%0d want 1 0 %h 0", ok, to, d, count, e);
        end
    endtask

    task automatic test_hold();
        bit ok, to, bad_hold, bad_pop, bad_push;
        logic [W-1:0] d, e;
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            issue(0, 1, 32'hB1 + W'(i), ok);
            ref_q.push_back(32'hB1 + W'(i));
        end
        back_rsp_ready = 1'b0;
        issue(0, 0, '0, ok);
        exp_back.push_back(ref_q.pop_back());
        wait_rsp(0, d, to);
        e = exp_back.pop_front();
        n_tests++;
        if (!ok || to || d !== e) begin
            n_fail++;
            $display("FAIL hold_first: ok=%b timeout=%b data=%h want 1 0 %h", ok, to, d, e);
        end
        bad_hold = 1'b0; bad_pop = 1'b0; bad_push = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) drive(0, 0, '0);
            if (k == 2) drive(0, 1, 32'hC1);
            #1;
            if (back_rsp_valid !== 1'b1 || back_rsp_data !== e) bad_hold = 1'b1;
            if (k == 1 && (back_req_ready !== 1'b0 || dq_back_pop !== 1'b0)) bad_pop = 1'b1;
            if (k == 2 && (back_req_ready !== 1'b1 || dq_back_push !== 1'b1)) bad_push = 1'b1;
            step();
            clear_req();
        end
        ref_q.push_back(32'hC1);
        n_tests++;
        if (bad_hold) begin n_fail++; $display("FAIL hold_stable: response not held, want valid=1 data=%h", e); end
        n_tests++;
        if (bad_pop) begin n_fail++; $display("FAIL hold_pop_refused: pop granted during RSP, want ready=0"); end
        n_tests++;
        if (bad_push) begin n_fail++; $display("FAIL hold_push: push refused during RSP, want ready=1"); end
        back_rsp_ready = 1'b1;
        step();
        n_tests++;
        if (back_rsp_valid !== 1'b0 || count !== CW'(3)) begin
            n_fail++;
            $display("FAIL hold_release: valid=%b count=%0d want 0 3", back_rsp_valid, count);
        end
        issue(0, 0, '0, ok);
        exp_back.push_back(ref_q.pop_back());
        wait_rsp(0, d, to);
        e = exp_back.pop_front();
        n_tests++;
        if (!ok || to || d !== e) begin
            n_fail++;
            $display("FAIL hold_next_pop: ok=%b timeout=%b data=%h want 1 0 %h", ok, to, d, e);
        end
    endtask

    task automatic test_async_reset();
        bit ok, to;
        logic [W-1:0] d;
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            issue(0, 1, 32'h300 + W'(i), ok);
        end
        back_rsp_ready = 1'b0;
        issue(0, 0, '0, ok);
        wait_rsp(0, d, to);
        n_tests++;
        if (to || back_rsp_valid !== 1'b1 || count !== CW'(7) || d !== 32'h307) begin
            n_fail++;
            $display("FAIL pre_reset: timeout=%b valid=%b count=%0d data=%h want 0 1 7 00000307",
                     to, back_rsp_valid, count, d);
        end
        drive(1, 1, 32'h77);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (back_rsp_valid !== 1'b0 || back_rsp_data !== '0 || count !== '0 ||
            front_req_ready !== 1'b0 || dq_front_push !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b data=%h count=%0d frdy=%b fpush=%b want all 0",
                     back_rsp_valid, back_rsp_data, count, front_req_ready, dq_front_push);
        end
        clear_req();
        back_rsp_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        n_tests++;
        if (count !== '0 || back_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: count=%0d valid=%b want 0 0", count, back_rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_full();
        test_conflict();
        test_empty();
        test_hold();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
